// File: rtl/fir_pkg.sv
// Shared sizing and state encoding for the time-multiplexed FIR controller.
package fir_pkg;

    localparam int TAPS = 74;
    localparam int AW   = 7;
    localparam int DW   = 8;

    typedef enum logic [2:0] {
        CLR   = 3'd0,
        IDLE  = 3'd1,
        WR    = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } fir_state_t;

endpackage

// File: rtl/fir_tdm_ctrl_if.sv
// Sample-input and coefficient-config handshakes of the FIR controller.
interface fir_tdm_ctrl_if #(
    parameter int AW = fir_pkg::AW,
    parameter int DW = fir_pkg::DW
);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic        [AW-1:0] cfg_addr;
    logic signed [DW-1:0] cfg_data;
    logic                 cfg_err;

    modport master (
        output in_valid, in_data, cfg_valid, cfg_addr, cfg_data,
        input  in_ready, cfg_ready, cfg_err
    );

    modport slave (
        input  in_valid, in_data, cfg_valid, cfg_addr, cfg_data,
        output in_ready, cfg_ready, cfg_err
    );

endinterface

// File: rtl/fir_mod_addr.sv
// Down-counting modulo-TAPS address register with load; drives the sample
// read address in RUN and the clear-sweep address in CLR.
module fir_mod_addr #(
    parameter int TAPS = fir_pkg::TAPS,
    parameter int AW   = fir_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          dec,
    output logic [AW-1:0] addr
);

    function automatic logic [AW-1:0] mod_dec(input logic [AW-1:0] a);
        logic [AW:0] d;
        d = {1'b0, a} - (AW+1)'(1);
        if (d[AW]) d = d + (AW+1)'(TAPS);
        return d[AW-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    addr <= '0;
        else if (load) addr <= load_val;
        else if (dec)  addr <= mod_dec(addr);
    end

endmodule

// File: rtl/fir_tdm_ctrl.sv
// Time-multiplexed FIR controller: stores each sample into a circular sample
// RAM, then sequences TAPS coefficient/sample reads into an external MAC.
module fir_tdm_ctrl #(
    parameter int TAPS = fir_pkg::TAPS,
    parameter int AW   = fir_pkg::AW,
    parameter int DW   = fir_pkg::DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fir_tdm_ctrl_if.slave        bus,
    output logic                 smp_we,
    output logic        [AW-1:0] smp_waddr,
    output logic signed [DW-1:0] smp_wdata,
    output logic        [AW-1:0] smp_raddr,
    output logic                 coef_we,
    output logic        [AW-1:0] coef_waddr,
    output logic signed [DW-1:0] coef_wdata,
    output logic        [AW-1:0] coef_raddr,
    output logic                 mac_clr,
    output logic                 mac_en,
    output logic                 out_valid,
    output logic                 busy
);

    import fir_pkg::*;

    fir_state_t    state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] head;
    logic [AW-1:0] k;
    logic          drn;
    logic [AW-1:0] cnt;
    logic [AW-1:0] clr_addr;
    logic          accept;
    logic          cfg_acc;
    logic          cfg_bad;
    logic          clr_last;
    logic          clr_wr;
    logic          run_last;

    function automatic logic [AW-1:0] mod_inc(input logic [AW-1:0] a);
        logic [AW:0] s;
        s = {1'b0, a} + (AW+1)'(1);
        if (s >= (AW+1)'(TAPS)) s = s - (AW+1)'(TAPS);
        return s[AW-1:0];
    endfunction

    // (TAPS - a) mod TAPS: turns the down-count 0,73,72.. into the sweep 0,1,2..
    function automatic logic [AW-1:0] mod_neg(input logic [AW-1:0] a);
        logic [AW:0] d;
        d = (AW+1)'(0) - {1'b0, a};
        if (d[AW]) d = d + (AW+1)'(TAPS);
        return d[AW-1:0];
    endfunction

    assign bus.in_ready  = (state == IDLE);
    assign bus.cfg_ready = (state == IDLE) && !bus.in_valid;
    assign busy          = (state != IDLE);

    assign accept   = (state == IDLE) && bus.in_valid;
    assign cfg_acc  = (state == IDLE) && !bus.in_valid && bus.cfg_valid;
    assign cfg_bad  = ({1'b0, bus.cfg_addr} >= (AW+1)'(TAPS));
    assign clr_last = smp_we && (smp_waddr == AW'(TAPS-1));
    assign clr_wr   = (state == CLR) && !clr_last;
    assign run_last = (k == AW'(TAPS-1));
    assign clr_addr = mod_neg(cnt);

    assign smp_raddr  = (state == RUN) ? cnt : '0;
    assign coef_raddr = (state == RUN) ? k   : '0;

    fir_mod_addr #(.TAPS(TAPS), .AW(AW)) u_addr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == WR),
        .load_val (wptr),
        .dec      ((state == RUN) || clr_wr),
        .addr     (cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLR;
            wptr        <= '0;
            head        <= '0;
            k           <= '0;
            drn         <= 1'b0;
            smp_we      <= 1'b0;
            coef_we     <= 1'b0;
            bus.cfg_err <= 1'b0;
            mac_en      <= 1'b0;
            mac_clr     <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            smp_we      <= 1'b0;
            coef_we     <= 1'b0;
            bus.cfg_err <= 1'b0;
            out_valid   <= 1'b0;
            // MAC strobes trail the read issue by the RAM read latency.
            mac_en      <= (state == RUN);
            mac_clr     <= (state == RUN) && (k == '0);
            case (state)
                CLR: begin
                    if (clr_last) state  <= IDLE;
                    else          smp_we <= 1'b1;
                end
                IDLE: begin
                    if (accept) begin
                        state  <= WR;
                        smp_we <= 1'b1;
                    end else if (cfg_acc) begin
                        coef_we     <= !cfg_bad;
                        bus.cfg_err <= cfg_bad;
                    end
                end
                WR: begin
                    head  <= wptr;
                    k     <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (run_last) begin
                        state <= DRAIN;
                        drn   <= 1'b0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drn) begin
                        state <= IDLE;
                        wptr  <= mod_inc(head);
                    end else begin
                        drn       <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= CLR;
            endcase
        end
    end

    // Write address/data are plain datapath registers, zeroed whenever no write is due.
    always_ff @(posedge clk) begin
        smp_waddr  <= accept ? wptr : (clr_wr ? clr_addr : '0);
        smp_wdata  <= accept ? bus.in_data : '0;
        coef_waddr <= (cfg_acc && !cfg_bad) ? bus.cfg_addr : '0;
        coef_wdata <= (cfg_acc && !cfg_bad) ? bus.cfg_data : '0;
    end

endmodule

// File: doc/fir_tdm_ctrl.md
FIR_TDM_CTRL -- requirements
Module: fir_tdm_ctrl

Interface
REQ-001 SHALL have parameter TAPS, default 74, the number of filter taps.
REQ-002 SHALL have parameter AW, default 7, the address width for the sample and coefficient RAMs.
REQ-003 SHALL have parameter DW, default 8, the signed sample and coefficient width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid / in_ready / in_data  in / out / DW  input sample handshake.
REQ-008 cfg_valid / cfg_ready / cfg_addr / cfg_data  in / out / AW / DW  coefficient write handshake.
REQ-009 cfg_err  out  1  one-cycle pulse when an accepted cfg_addr is >= TAPS.
REQ-010 smp_we / smp_waddr / smp_wdata  out / AW / DW  sample RAM write port.
REQ-011 smp_raddr  out  AW  sample RAM read address; the RAM has 1-cycle read latency.
REQ-012 coef_we / coef_waddr / coef_wdata  out / AW / DW  coefficient RAM write port.
REQ-013 coef_raddr  out  AW  coefficient RAM read address; the RAM has 1-cycle read latency.
REQ-014 mac_clr / mac_en  out / 1  MAC control; mac_clr loads the product instead of accumulating it.
REQ-015 out_valid  out  1  one-cycle pulse; the external MAC accumulator is final in this cycle.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 SHALL implement the states CLR, IDLE, WR, RUN and DRAIN, all registered.
REQ-018 CLR: SHALL write 0 to sample addresses 0..TAPS-1, one per cycle, then go to IDLE; in_ready and cfg_ready SHALL be 0 throughout.
REQ-019 IDLE: in_ready SHALL be 1; a sample is accepted on in_valid&&in_ready, and the next state SHALL be WR.
REQ-020 WR: SHALL drive smp_we=1, smp_waddr=wptr and smp_wdata=the captured sample for exactly 1 cycle, latch head=wptr, then go to RUN.
REQ-021 RUN: for k=0..TAPS-1, one per cycle, SHALL drive coef_raddr=k and smp_raddr=(head-k) mod TAPS; after k=TAPS-1 the next state SHALL be DRAIN.
REQ-022 mac_en SHALL equal the RUN issue strobe delayed 1 cycle; mac_clr SHALL be high only together with the first mac_en.
REQ-023 DRAIN: SHALL last 2 cycles; out_valid SHALL pulse in the second cycle, wptr SHALL advance by one (mod TAPS, 73 wraps to 0), and the next state SHALL be IDLE.
REQ-024 Latency: for an accept in cycle T, mac_en SHALL be high in T+3..T+TAPS+2, out_valid SHALL pulse in T+TAPS+3, and in_ready SHALL return in T+TAPS+4.
REQ-025 cfg_ready SHALL be 1 only in IDLE with in_valid=0; when sample and cfg requests arrive in the same cycle, the sample wins.
REQ-026 An accepted cfg SHALL produce coef_we=1 in the next cycle, with address and data as registered.
REQ-027 If cfg_addr >= TAPS, the write SHALL be suppressed and cfg_err SHALL pulse in the next cycle.
REQ-028 Modulo subtraction SHALL use a conditional add of TAPS, with no divider; all address arithmetic SHALL be AW+1 bits.
REQ-029 Outputs not named in a state SHALL be 0 in that state.

Reset
REQ-030 On rst_n=0, state SHALL become CLR immediately and asynchronously, including during RUN or DRAIN.
REQ-031 On reset, wptr=0, head=0, k=0.
REQ-032 On reset, all strobes (smp_we, coef_we, mac_en, mac_clr, out_valid, cfg_err) SHALL be 0, as SHALL in_ready and cfg_ready; busy SHALL be 1.
REQ-033 A sample or cfg in flight at reset SHALL be discarded; coefficient RAM contents are preserved.

Structure
REQ-034 Package fir_pkg SHALL hold TAPS, AW, DW and the state enum fir_state_t.
REQ-035 Sub-module fir_mod_addr (down-counting modulo-TAPS address, with load and decrement) SHALL generate smp_raddr and the CLR write address.

Verification
REQ-036 Reset release -> smp_we high with waddr 0..73 for 74 cycles, then in_ready=1 in cycle 75.
REQ-037 Sample 0x7F accepted at T with wptr=0 -> smp_raddr sequence 0, 73, 72, ..., 1; mac_clr at T+3; out_valid at T+77.
REQ-038 74 consecutive samples -> the 75th is written at address 0 (wrap), and its RUN starts at smp_raddr=0, then 73.
REQ-039 in_valid and cfg_valid high together in IDLE -> sample accepted, cfg_ready=0; cfg accepted at the first IDLE cycle with in_valid=0.
REQ-040 cfg_addr=74, data 0x12 -> coef_we stays 0 and cfg_err pulses once; cfg_addr=5 -> coef_we=1 with waddr 5 and wdata 0x12.
REQ-041 rst_n low at RUN k=30 -> all strobes 0 immediately; after release, CLR repeats and out_valid never pulses for the aborted sample.
